ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver for the terminal's keyboard input (ps2_clk/ps2_data pins).
- Synchronises and deglitches the PS/2 lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks them.
- Presents each scancode as a one-beat AXI-stream byte for the downstream keyboard/command path, alongside the UART byte stream.
- Single clock domain: the system clk.

Parameters:
- SYNC_STAGES, 3, flip-flop synchroniser depth on ps2_clk and ps2_data.
- FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 50000, clk cycles without a falling edge mid-frame before the frame is aborted (about 2 ms at 25 MHz).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- m_axis_tdata  out  8  received scancode byte.
- m_axis_tuser  out  2  {break, extended} flags; 2'b00 unless PS2_MAKEBREAK_EN.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tready  in  1  downstream accepts the byte.
- parity_error  out  1  one-cycle pulse on a parity failure.
- frame_error  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset (rstn=0, asynchronous):
  - tdata=0, tuser=0, tvalid=0, all pulses 0, state IDLE.
  - Filtered ps2_clk=1; synchroniser flops=1.
- Input path:
  - Both lines pass through SYNC_STAGES flops.
  - Filtered ps2_clk toggles only after FILTER_LEN identical samples.
  - fall = one-cycle strobe on filtered 1->0. Data is sampled from synchronised ps2_data on fall.
  - Input latency: SYNC_STAGES+FILTER_LEN clk.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bitcnt=0. On fall with data=1, pulse frame_error and stay in IDLE.
  - DATA: on fall, shift data into sr[7] (LSB first). After 8 bits, go to PARITY.
  - PARITY: on fall, latch p and go to STOP.
  - STOP: on fall, return to IDLE.
    - stop=0: frame_error pulse, byte discarded.
    - ^{sr,p}==0: parity_error pulse, byte discarded.
    - Otherwise the byte completes.
  - Timeout: a counter is cleared on every fall and counts in every non-IDLE state. At TIMEOUT_CYCLES-1 go to IDLE and pulse frame_error. Partial data is discarded.
- Output handshake: single-entry register.
  - On completion with tvalid=0 or (tvalid&tready): tdata<=sr and tvalid<=1 on the next clk edge.
  - tvalid is held with tdata/tuser stable until tready=1.
  - A beat transfers on a cycle with tvalid&tready; tvalid drops on the next edge unless a new byte loads in the same cycle.
  - Completion while tvalid&~tready: the new byte is dropped, overrun is pulsed and the old byte is kept.
- Simultaneous error conditions: frame_error takes precedence; only one error pulse per frame.

Optional Feature:
- Macro: PS2_MAKEBREAK_EN.
- Defined:
  - Valid bytes 0xE0 and 0xF0 are absorbed and never output. They set the pending flags ext and brk.
  - The next non-prefix byte is output with tuser={brk,ext}; both flags clear when that byte loads or is dropped.
  - A parity, frame or timeout error also clears both flags.
- Undefined: every valid byte, including prefixes, is output raw; tuser is tied to 2'b00.

Decomposition:
- Shared package vt52_pkg:
  - state enum ps2_state_t.
  - PS2_FRAME_BITS=11, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0.
- Sub-module ps2_line_filter: synchroniser, glitch filter and falling-edge strobe. Instantiated once for clk; the data line uses its synchroniser only.

Test Plan:
- Frame 0x1C, parity 0, stop 1, tready=1 -> one beat, tdata=0x1C, tuser=0; no error pulses.
- Frame 0x1C with parity 1 -> parity_error pulses once, no tvalid; a following frame 0x5A delivers tdata=0x5A.
- Start bit then 5 data bits, then clock idle -> frame_error after TIMEOUT_CYCLES; the next frame 0x32 is received correctly.
- tready=0; frames 0x1C then 0x32 -> tdata stays 0x1C, overrun pulses once; after tready=1 exactly one beat 0x1C.
- 2-cycle low glitch on ps2_clk in IDLE (glitch < FILTER_LEN) -> no state change, no outputs.
- PS2_MAKEBREAK_EN: frames F0,1C -> one beat 0x1C, tuser=2'b10; frames E0,F0,75 -> one beat 0x75, tuser=2'b11.

Source files
------------

// File: rtl/vt52_pkg.sv
// Shared types and constants for the terminal's PS/2 keyboard receive path.
package vt52_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock line conditioning: synchroniser, level filter, falling-edge strobe.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic line_i,
    output logic fall_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        // Level flips only after FILTER_LEN consecutive disagreeing samples.
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver presenting scancodes as one-byte AXI-stream beats.
// Define PS2_MAKEBREAK_EN to fold E0/F0 prefixes into tuser {break, extended}.
module ps2_keyboard_rx
    import vt52_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] m_axis_tdata,
    output logic [1:0] m_axis_tuser,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic                   fall;
    logic                   din;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;

    ps2_state_t state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          done;
    logic          deliver;
    logic [1:0]    flags;

`ifdef PS2_MAKEBREAK_EN
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [1:0] tuser_q, tuser_d;
`endif

    ps2_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .clk   (clk),
        .rstn  (rstn),
        .line_i(ps2_clk),
        .fall_o(fall)
    );

    assign dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    assign din     = dsync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        par_d    = par_q;
        tcnt_d   = tcnt_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (fall) begin
                    if (!din) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    sr_d = {din, sr_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = din;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!din) begin
                        ferr_d = 1'b1;
                    end else if (^{sr_q, par_q} == 1'b0) begin
                        perr_d = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end else if (fall) begin
            tcnt_d = '0;
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ovr_d    = 1'b0;
`ifdef PS2_MAKEBREAK_EN
        ext_d    = ext_q;
        brk_d    = brk_q;
        tuser_d  = tuser_q;
        flags    = {brk_q, ext_q};
        deliver  = done && sr_q != PS2_PREFIX_EXT
                        && sr_q != PS2_PREFIX_BRK;
        if (done && sr_q == PS2_PREFIX_EXT) ext_d = 1'b1;
        if (done && sr_q == PS2_PREFIX_BRK) brk_d = 1'b1;
        if (deliver || perr_d || ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
`else
        flags    = 2'b00;
        deliver  = done;
`endif
        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
        // Single-entry buffer: a byte arriving while it is still held is lost.
        if (deliver) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = sr_q;
                tvalid_d = 1'b1;
`ifdef PS2_MAKEBREAK_EN
                tuser_d  = flags;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dsync_q  <= '1;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sr_q     <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            dsync_q  <= dsync_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef PS2_MAKEBREAK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            tuser_q <= 2'b00;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            tuser_q <= tuser_d;
        end
    end

    assign m_axis_tuser = tuser_q;
`else
    assign m_axis_tuser = 2'b00;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign parity_error  = perr_q;
    assign frame_error   = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx with a frame-level reference model.
module tb_ps2_keyboard_rx;

    localparam int SYNC = 3;
    localparam int FILT = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       tready = 1'b1;
    logic [7:0] tdata;
    logic [1:0] tuser;
    logic       tvalid;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .m_axis_tdata (tdata),
        .m_axis_tuser (tuser),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] beat_q[$];
    logic [9:0] exp_q[$];
    int n_par, n_frm, n_ovr;
    bit m_ext, m_brk;
    bit hold_prev = 1'b0;
    logic [9:0] hold_val;

    always @(negedge clk) begin
        if (rstn) begin
            if (hold_prev) begin
                n_tests++;
                if (!(tvalid === 1'b1 && {tuser, tdata} === hold_val)) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b %h, want v=1 %h",
                             tvalid, {tuser, tdata}, hold_val);
                end
            end
            hold_prev = tvalid & ~tready;
            hold_val  = {tuser, tdata};
            if (tvalid && tready) beat_q.push_back({tuser, tdata});
            if (parity_error) n_par++;
            if (frame_error) n_frm++;
            if (overrun) n_ovr++;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic clear_obs();
        beat_q.delete();
        exp_q.delete();
        n_par = 0;
        n_frm = 0;
        n_ovr = 0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // err: 0 good, 1 wrong parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int err);
        logic p;
        p = ~^b;
        if (err == 1) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(err == 2 ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    function automatic void model_byte(input logic [7:0] b, input int err);
        if (err != 0) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            return;
        end
`ifdef PS2_MAKEBREAK_EN
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back({m_brk, m_ext, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
`else
        exp_q.push_back({2'b00, b});
`endif
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        wait_clks(5);
        n_tests++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b want 0", tvalid);
        end
        n_tests++;
        if ({tuser, tdata} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 000", {tuser, tdata});
        end
        n_tests++;
        if ({parity_error, frame_error, overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 000",
                     {parity_error, frame_error, overrun});
        end
        rstn = 1'b1;
        wait_clks(40);
        clear_obs();
    endtask

    task automatic test_basic();
        clear_obs();
        tready = 1'b1;
        send_frame(8'h1C, 0);
        n_tests++;
        if (beat_q.size() != 1 || beat_q[0] !== 10'h01C) begin
            n_fail++;
            $display("FAIL basic_beat: got n=%0d %h want n=1 01C",
                     beat_q.size(), beat_q.size() ? beat_q[0] : 10'h3FF);
        end
        n_tests++;
        if (n_par + n_frm + n_ovr != 0) begin
            n_fail++;
            $display("FAIL basic_errors: got %0d/%0d/%0d want 0/0/0",
                     n_par, n_frm, n_ovr);
        end
    endtask

    task automatic test_parity();
        clear_obs();
        send_frame(8'h1C, 1);
        n_tests++;
        if (n_par != 1 || n_frm != 0 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL parity: got par=%0d frm=%0d beats=%0d want 1 0 0",
                     n_par, n_frm, beat_q.size());
        end
        send_frame(8'h5A, 0);
        n_tests++;
        if (beat_q.size() != 1 || beat_q[0] !== 10'h05A) begin
            n_fail++;
            $display("FAIL parity_next: got n=%0d %h want n=1 05A",
                     beat_q.size(), beat_q.size() ? beat_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_stop();
        clear_obs();
        send_frame(8'hA7, 2);
        n_tests++;
        if (n_frm != 1 || n_par != 0 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL stop: got frm=%0d par=%0d beats=%0d want 1 0 0",
                     n_frm, n_par, beat_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        clear_obs();
        b = 8'h15;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        ps2_data = 1'b1;
        wait_clks(TMO / 2);
        n_tests++;
        if (n_frm != 0) begin
            n_fail++;
            $display("FAIL timeout_early: got frm=%0d want 0", n_frm);
        end
        wait_clks(TMO / 2 + 200);
        n_tests++;
        if (n_frm != 1 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: got frm=%0d beats=%0d want 1 0",
                     n_frm, beat_q.size());
        end
        send_frame(8'h32, 0);
        n_tests++;
        if (beat_q.size() != 1 || beat_q[0] !== 10'h032) begin
            n_fail++;
            $display("FAIL timeout_next: got n=%0d %h want n=1 032",
                     beat_q.size(), beat_q.size() ? beat_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_overrun();
        clear_obs();
        @(posedge clk);
        #1 tready = 1'b0;
        send_frame(8'h1C, 0);
        send_frame(8'h32, 0);
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 8'h1C) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%b %h want v=1 1C", tvalid, tdata);
        end
        n_tests++;
        if (n_ovr != 1 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_pulse: got ovr=%0d beats=%0d want 1 0",
                     n_ovr, beat_q.size());
        end
        @(posedge clk);
        #1 tready = 1'b1;
        wait_clks(10);
        n_tests++;
        if (beat_q.size() != 1 || beat_q[0] !== 10'h01C || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got n=%0d %h v=%b want n=1 01C v=0",
                     beat_q.size(), beat_q.size() ? beat_q[0] : 10'h3FF, tvalid);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(50);
        n_tests++;
        if (n_frm + n_par + n_ovr != 0 || beat_q.size() != 0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got frm=%0d beats=%0d v=%b want 0 0 0",
                     n_frm, beat_q.size(), tvalid);
        end
        send_frame(8'h6B, 0);
        n_tests++;
        if (beat_q.size() != 1 || beat_q[0] !== 10'h06B) begin
            n_fail++;
            $display("FAIL glitch_next: got n=%0d %h want n=1 06B",
                     beat_q.size(), beat_q.size() ? beat_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_makebreak();
        clear_obs();
        tready = 1'b1;
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
`ifdef PS2_MAKEBREAK_EN
        exp_q = '{10'h21C, 10'h375};
`else
        exp_q = '{10'h0F0, 10'h01C, 10'h0E0, 10'h0F0, 10'h075};
`endif
        n_tests++;
        if (beat_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL makebreak_count: got %0d want %0d",
                     beat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
            n_tests++;
            if (beat_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL makebreak_beat%0d: got %h want %h",
                         i, beat_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int exp_par, exp_frm, err;
        logic [7:0] b;
        clear_obs();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_par = 0;
        exp_frm = 0;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            err = $urandom_range(0, 5);
            if (err > 2) err = 0;
            if (err == 1) exp_par++;
            if (err == 2) exp_frm++;
            @(posedge clk);
            #1 tready = 1'($urandom);
            send_frame(b, err);
            model_byte(b, err);
            @(posedge clk);
            #1 tready = 1'b1;
            wait_clks(4);
        end
        n_tests++;
        if (n_par != exp_par || n_frm != exp_frm || n_ovr != 0) begin
            n_fail++;
            $display("FAIL random_errors: got %0d/%0d/%0d want %0d/%0d/0",
                     n_par, n_frm, n_ovr, exp_par, exp_frm);
        end
        n_tests++;
        if (beat_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d want %0d",
                     beat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
            n_tests++;
            if (beat_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_beat%0d: got %h want %h",
                         i, beat_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_timeout();
        test_overrun();
        test_glitch();
        test_makebreak();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
